game_ctrl: RTL

Game sequencer for the Pong datapath. It drives the 2-bit `game_state` consumed by the pixel renderer: 00 start screen, 01 field, 10 player-1-wins fill, 11 player-2-wins fill. It keeps both scores, times the serve delay and the end-of-game hold from the 1 ms tick, and issues ball reset, freeze and serve-direction controls to the ball/paddle logic.

---
 rtl/game_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: Pong game sequencer. Tracks scores, times the serve delay and
// the end-of-game hold from the 1 ms tick, and drives the renderer mode and
// the ball/paddle control signals. Every output is a flop.
module game_ctrl #(
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned SERVE_DELAY_MS = 1000,
  parameter int unsigned END_HOLD_MS    = 3000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1ms,
  input  logic       start,
  input  logic       sp,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [1:0] game_state,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       ball_reset,
  output logic       freeze,
  output logic       serve_dir
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WIN1  = 3'd3,
    ST_WIN2  = 3'd4
  } state_e;

  localparam logic [3:0]  WIN_PTS    = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_LAST = 16'(SERVE_DELAY_MS - 1);
  localparam logic [15:0] HOLD_DONE  = 16'(END_HOLD_MS);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  score1_q, score1_d;
  logic [3:0]  score2_q, score2_d;
  logic        serve_dir_q, serve_dir_d;
  logic        start_prev_q, start_prev_d;
  logic [1:0]  game_state_q, game_state_d;
  logic        ball_reset_q, ball_reset_d;
  logic        freeze_q, freeze_d;

  logic        start_edge;
  logic [3:0]  score1_inc;
  logic [3:0]  score2_inc;

  assign start_edge = start & ~start_prev_q;
  assign score1_inc = score1_q + 4'd1;
  assign score2_inc = score2_q + 4'd1;

  // Next-state, score, timer and serve-direction logic for the game sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d      = state_q;
    timer_d      = timer_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    serve_dir_d  = serve_dir_q;
    start_prev_d = start;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d     = ST_SERVE;
          timer_d     = '0;
          score1_d    = '0;
          score2_d    = '0;
          serve_dir_d = 1'b1;
        end
      end

      ST_SERVE: begin
        // Start and misses are deliberately ignored while the ball is held.
        if (tick_1ms) begin
          if (timer_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
      end

      ST_PLAY: begin
        // Timer is idle in play so every following state starts from zero.
        timer_d = '0;
        if (miss_left && miss_right) begin
          state_d = ST_SERVE;
        end else if (miss_left) begin
          score2_d    = score2_inc;
          serve_dir_d = 1'b0;
          state_d     = (score2_inc == WIN_PTS) ? ST_WIN2 : ST_SERVE;
        end else if (miss_right && !sp) begin
          score1_d    = score1_inc;
          serve_dir_d = 1'b1;
          state_d     = (score1_inc == WIN_PTS) ? ST_WIN1 : ST_SERVE;
        end
      end

      ST_WIN1, ST_WIN2: begin
        // Hold timer saturates; only then may a new game start.
        if (tick_1ms && (timer_q != HOLD_DONE)) begin
          timer_d = timer_q + 16'd1;
        end
        if (start_edge && (timer_q == HOLD_DONE)) begin
          state_d     = ST_SERVE;
          timer_d     = '0;
          score1_d    = '0;
          score2_d    = '0;
          serve_dir_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Output values are derived from the next state so they register alongside it.
  always_comb begin
    game_state_d = 2'b00;
    unique case (state_d)
      ST_SERVE, ST_PLAY: game_state_d = 2'b01;
      ST_WIN1:           game_state_d = 2'b10;
      ST_WIN2:           game_state_d = 2'b11;
      default:           game_state_d = 2'b00;
    endcase
    freeze_d     = (state_d != ST_PLAY);
    ball_reset_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      serve_dir_q  <= 1'b1;
      // Resets high so a button held through reset is not seen as a press.
      start_prev_q <= 1'b1;
      game_state_q <= 2'b00;
      ball_reset_q <= 1'b0;
      freeze_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      serve_dir_q  <= serve_dir_d;
      start_prev_q <= start_prev_d;
      game_state_q <= game_state_d;
      ball_reset_q <= ball_reset_d;
      freeze_q     <= freeze_d;
    end
  end

  assign game_state = game_state_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign ball_reset = ball_reset_q;
  assign freeze     = freeze_q;
  assign serve_dir  = serve_dir_q;

endmodule
